// File: rtl/pll_adf4158.sv
// Power-up programmer for the ADF4158: shifts R7..R0 over the 3-wire bus once
// per reset, then parks the bus idle.
module pll_adf4158 #(
  parameter logic [31:0] R0_VAL      = 32'h0000_0000,
  parameter logic [31:0] R1_VAL      = 32'h0000_0001,
  parameter logic [31:0] R2_VAL      = 32'h0000_0002,
  parameter logic [31:0] R3_VAL      = 32'h0000_0003,
  parameter logic [31:0] R4_VAL      = 32'h0000_0004,
  parameter logic [31:0] R5_VAL      = 32'h0000_0005,
  parameter logic [31:0] R6_VAL      = 32'h0000_0006,
  parameter logic [31:0] R7_VAL      = 32'h0000_0007,
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned START_DELAY = 16,
  parameter int unsigned LE_PULSE    = 2,
  parameter int unsigned GAP         = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic writeData,
  output logic loadEnable,
  output logic pll_clk
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SHIFT,
    ST_SETTLE,
    ST_LATCH,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_hi_q, phase_hi_d;
  logic [4:0]  bit_q, bit_d;
  logic [2:0]  word_q, word_d;
  logic        wd_q, wd_d;
  logic        le_q, le_d;
  logic        sclk_q, sclk_d;
  logic [31:0] cur_word, next_word;

  // Word index 0 is R7; the low three bits always carry the register address.
  function automatic logic [31:0] word_for(input logic [2:0] idx);
    logic [31:0] base;
    case (idx)
      3'd0: base = R7_VAL;
      3'd1: base = R6_VAL;
      3'd2: base = R5_VAL;
      3'd3: base = R4_VAL;
      3'd4: base = R3_VAL;
      3'd5: base = R2_VAL;
      3'd6: base = R1_VAL;
      3'd7: base = R0_VAL;
    endcase
    return {base[31:3], ~idx};
  endfunction

  // True on the last cycle of a span lasting len cycles (len of 0 acts as 1).
  function automatic logic span_end(input logic [7:0] c, input int unsigned len);
    return (32'(c) + 32'd1) >= len;
  endfunction

  assign cur_word  = word_for(word_q);
  assign next_word = word_for(word_q + 3'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    phase_hi_d = phase_hi_q;
    bit_d      = bit_q;
    word_d     = word_q;
    wd_d       = wd_q;
    le_d       = le_q;
    sclk_d     = sclk_q;
    case (state_q)
      ST_WAIT: begin
        if (span_end(cnt_q, START_DELAY)) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          phase_hi_d = 1'b0;
          bit_d      = 5'd31;
          wd_d       = cur_word[31];
          sclk_d     = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (span_end(cnt_q, HALF_PERIOD)) begin
          cnt_d = '0;
          if (!phase_hi_q) begin
            phase_hi_d = 1'b1;
            sclk_d     = 1'b1;
          end else if (bit_q == 5'd0) begin
            state_d    = ST_SETTLE;
            phase_hi_d = 1'b0;
            sclk_d     = 1'b0;
          end else begin
            // New bit is presented together with the falling edge.
            phase_hi_d = 1'b0;
            sclk_d     = 1'b0;
            bit_d      = bit_q - 5'd1;
            wd_d       = cur_word[bit_q - 5'd1];
          end
        end
      end
      ST_SETTLE: begin
        if (span_end(cnt_q, HALF_PERIOD)) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
          le_d    = 1'b1;
          wd_d    = 1'b0;
        end
      end
      ST_LATCH: begin
        if (span_end(cnt_q, LE_PULSE)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          le_d    = 1'b0;
        end
      end
      ST_GAP: begin
        if (span_end(cnt_q, GAP)) begin
          cnt_d = '0;
          if (word_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_SHIFT;
            word_d     = word_q + 3'd1;
            bit_d      = 5'd31;
            phase_hi_d = 1'b0;
            wd_d       = next_word[31];
          end
        end
      end
      ST_DONE: begin
        cnt_d  = cnt_q;
        wd_d   = 1'b0;
        le_d   = 1'b0;
        sclk_d = 1'b0;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT;
      cnt_q      <= '0;
      phase_hi_q <= 1'b0;
      bit_q      <= '0;
      word_q     <= '0;
      wd_q       <= 1'b0;
      le_q       <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_hi_q <= phase_hi_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      wd_q       <= wd_d;
      le_q       <= le_d;
      sclk_q     <= sclk_d;
    end
  end

  assign writeData  = wd_q;
  assign loadEnable = le_q;
  assign pll_clk    = sclk_q;

endmodule

// File: tb/tb_pll_adf4158.sv
// Bench for pll_adf4158: three instances (defaults, overridden R3/R0, HALF_PERIOD=3)
// checked cycle by cycle against a waveform model, plus a mid-word reset run.
module tb_pll_adf4158;

  logic clk = 1'b0;
  always #25 clk = ~clk;

  logic       ra;
  logic       rbc;
  logic [2:0] pc;
  logic [2:0] wd;
  logic [2:0] le;

  pll_adf4158 u_def (
    .clk(clk), .reset_n(ra), .writeData(wd[0]), .loadEnable(le[0]), .pll_clk(pc[0])
  );

  pll_adf4158 #(.R3_VAL(32'hFFFF_FFF8), .R0_VAL(32'hFFFF_FFFF)) u_ovr (
    .clk(clk), .reset_n(rbc), .writeData(wd[1]), .loadEnable(le[1]), .pll_clk(pc[1])
  );

  pll_adf4158 #(.HALF_PERIOD(3)) u_hp3 (
    .clk(clk), .reset_n(rbc), .writeData(wd[2]), .loadEnable(le[2]), .pll_clk(pc[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  int          rises[3];
  int          first_rise[3];
  int          pulses[3];
  int          bits_in_word[3];
  int          le_width[3];
  int          last_le_start[3];
  logic [31:0] cap[3];
  logic [31:0] caps[3][8];
  logic        p_clk[3];
  logic        p_wd[3];
  logic        p_le[3];

  logic [31:0] ovr_words[8] = '{32'h7, 32'h6, 32'h5, 32'h4,
                                32'hFFFF_FFFB, 32'h2, 32'h1, 32'hFFFF_FFF8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Word shifted in position w (0 = R7): register value with address bits replaced.
  function automatic logic [31:0] exp_word(input int set, input int w);
    int n;
    logic [31:0] base;
    n = 7 - w;
    base = 32'(n);
    if (set == 1 && n == 3) base = 32'hFFFF_FFF8;
    if (set == 1 && n == 0) base = 32'hFFFF_FFFF;
    return {base[31:3], 3'(n)};
  endfunction

  // Expected {pll_clk, writeData, loadEnable} in cycle t after reset release.
  function automatic logic [2:0] model(input int set, input int t);
    int hp, per, tt, w, r, b;
    logic [31:0] word;
    hp  = (set == 2) ? 3 : 2;
    per = 65 * hp + 2 + 4;
    if (t < 16) return 3'b000;
    tt = t - 16;
    w  = tt / per;
    r  = tt % per;
    if (w >= 8) return 3'b000;
    word = exp_word(set, w);
    if (r < 64 * hp) begin
      b = r / (2 * hp);
      return {((r % (2 * hp)) >= hp), word[31 - b], 1'b0};
    end
    if (r < 65 * hp) return {1'b0, word[0], 1'b0};
    if (r < 65 * hp + 2) return 3'b001;
    return 3'b000;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      rises[i] = 0;
      first_rise[i] = -1;
      pulses[i] = 0;
      bits_in_word[i] = 0;
      le_width[i] = 0;
      last_le_start[i] = -1;
      cap[i] = '0;
      p_clk[i] = 1'b0;
      p_wd[i] = 1'b0;
      p_le[i] = 1'b0;
      for (int k = 0; k < 8; k++) caps[i][k] = '0;
    end
  endtask

  task automatic cmp_cycle(input int t, input int n_inst);
    for (int i = 0; i < n_inst; i++) begin
      logic [2:0] e;
      logic [2:0] a;
      int per;
      per = (i == 2) ? 201 : 136;
      e = model(i, t);
      a = {pc[i], wd[i], le[i]};
      chk($sformatf("wave u%0d t=%0d {clk,data,le}", i, t), 32'(a), 32'(e));
      if (pc[i] && !p_clk[i]) begin
        rises[i]++;
        bits_in_word[i]++;
        cap[i] = {cap[i][30:0], wd[i]};
        if (first_rise[i] < 0) first_rise[i] = t;
      end
      if (i == 2 && t > 0)
        chk($sformatf("hp3 data change while clk high t=%0d", t),
            32'(pc[i] && (wd[i] != p_wd[i])), 32'd0);
      if (le[i] && !p_le[i]) begin
        chk($sformatf("u%0d bits before pulse %0d", i, pulses[i]), 32'(bits_in_word[i]), 32'd32);
        bits_in_word[i] = 0;
        if (pulses[i] < 8) caps[i][pulses[i]] = cap[i];
        if (last_le_start[i] >= 0)
          chk($sformatf("u%0d pulse spacing %0d", i, pulses[i]), 32'(t - last_le_start[i]), 32'(per));
        last_le_start[i] = t;
        pulses[i]++;
        le_width[i] = 0;
      end
      if (le[i]) le_width[i]++;
      if (!le[i] && p_le[i])
        chk($sformatf("u%0d pulse width %0d", i, pulses[i]), 32'(le_width[i]), 32'd2);
      p_clk[i] = pc[i];
      p_wd[i]  = wd[i];
      p_le[i]  = le[i];
    end
  endtask

  task automatic final_checks(input int n_inst, input string tag);
    for (int i = 0; i < n_inst; i++) begin
      chk($sformatf("%s u%0d rises", tag, i), 32'(rises[i]), 32'd256);
      chk($sformatf("%s u%0d pulses", tag, i), 32'(pulses[i]), 32'd8);
      chk($sformatf("%s u%0d first rise", tag, i), 32'(first_rise[i]), (i == 2) ? 32'd19 : 32'd18);
      for (int k = 0; k < 8; k++)
        chk($sformatf("%s u%0d word %0d", tag, i, k), caps[i][k],
            (i == 1) ? ovr_words[k] : 32'(7 - k));
    end
  endtask

  initial begin
    ra  = 1'b0;
    rbc = 1'b0;
    clear_stats();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset outputs c=%0d", c), 32'({pc, wd, le}), 32'd0);
    end

    @(negedge clk);
    ra  = 1'b1;
    rbc = 1'b1;
    for (int t = 0; t < 1700; t++) begin
      #1;
      cmp_cycle(t, 3);
      @(negedge clk);
    end
    final_checks(3, "run1");

    // Mid-word reset: abort the default instance during R5 bit 10.
    ra = 1'b0;
    repeat (5) @(negedge clk);
    ra = 1'b1;
    clear_stats();
    for (int t = 0; t <= 374; t++) begin
      #1;
      cmp_cycle(t, 1);
      if (t < 374) @(negedge clk);
    end
    #1;
    chk("clk high before abort", 32'(pc[0]), 32'd1);
    ra = 1'b0;
    #1;
    chk("async clear on abort", 32'({pc[0], wd[0], le[0]}), 32'd0);
    repeat (4) @(negedge clk);
    ra = 1'b1;
    clear_stats();
    for (int t = 0; t < 1150; t++) begin
      #1;
      cmp_cycle(t, 1);
      @(negedge clk);
    end
    final_checks(1, "restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_adf4158.md
Name: pll_adf4158

Overview:
Power-up serial programmer for the ADF4158 FMCW frequency synthesizer. After reset release it shifts a fixed sequence of eight 32-bit control words (R7 down to R0) into the chip over its 3-wire interface: clock, data and load-enable. It then parks the bus idle until the next reset. It sits at the top of the radar front-end and has no host-side handshake.

Parameters:
R0_VAL, 32'h0000_0000, FRAC/INT register word; bits [2:0] are overridden with 3'b000.
R1_VAL, 32'h0000_0001, LSB FRAC/phase word; bits [2:0] are overridden with 3'b001.
R2_VAL, 32'h0000_0002, R-divider/CLK1 word; bits [2:0] are overridden with 3'b010.
R3_VAL, 32'h0000_0003, function word; bits [2:0] are overridden with 3'b011.
R4_VAL, 32'h0000_0004, test/CLK2 word; bits [2:0] are overridden with 3'b100.
R5_VAL, 32'h0000_0005, deviation word; bits [2:0] are overridden with 3'b101.
R6_VAL, 32'h0000_0006, step word; bits [2:0] are overridden with 3'b110.
R7_VAL, 32'h0000_0007, delay word; bits [2:0] are overridden with 3'b111.
HALF_PERIOD, 2, number of clk cycles per pll_clk phase (low or high); must be >= 1.
START_DELAY, 16, number of clk cycles from reset release to the first bit.
LE_PULSE, 2, number of clk cycles loadEnable stays high per word.
GAP, 4, number of clk cycles with loadEnable low between words.

Ports:
clk  input  1  system clock (20 MHz, 50 ns period in the bench).
reset_n  input  1  asynchronous, active-low reset.
writeData  output  1  serial data to ADF4158 DATA pin, MSB first.
loadEnable  output  1  to ADF4158 LE pin; a high pulse latches the word just shifted.
pll_clk  output  1  serial clock to ADF4158 CLK pin.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset (asynchronous, while reset_n=0): pll_clk=0, writeData=0, loadEnable=0. State=WAIT, word index=0, all counters cleared. Asserting reset mid-operation aborts immediately; programming restarts from R7 after release.
- All outputs are registered and change only on the rising edge of clk.
- FSM states: WAIT, SHIFT, SETTLE, LATCH, GAP, DONE.
- WAIT: hold outputs idle for START_DELAY cycles, then load word 0 and enter SHIFT.
- Word order: R7, R6, R5, R4, R3, R2, R1, R0, giving 8 words. The shifted word equals {Rn_VAL[31:3], n[2:0]}.
- SHIFT, per bit, MSB (bit 31) first:
  - Low phase: writeData is updated to the current bit on the first cycle of the low phase. pll_clk=0 for HALF_PERIOD cycles.
  - High phase: pll_clk=1 for HALF_PERIOD cycles while writeData is held stable. The device samples on the pll_clk rising edge, so data is stable for HALF_PERIOD cycles before and after that edge.
  - Each bit takes 2*HALF_PERIOD cycles; 32 bits take 64*HALF_PERIOD cycles. loadEnable=0 throughout.
- SETTLE: after the 32nd high phase, pll_clk=0 and writeData holds bit 0 for HALF_PERIOD cycles.
- LATCH: loadEnable=1 for LE_PULSE cycles; pll_clk=0; writeData=0.
- GAP: loadEnable=0 for GAP cycles. Then go to the next word in SHIFT, or to DONE after R0.
- DONE: terminal state. pll_clk=0, writeData=0, loadEnable=0 forever; only reset leaves it.
- pll_clk never toggles outside SHIFT. Exactly 32 rising edges of pll_clk occur per loadEnable pulse, and exactly 8 loadEnable pulses occur per reset.
- Counters must be wide enough for parameter values up to 255.

Test Plan:
- Reset hold: keep reset_n=0 for 10 cycles, then release -> all outputs stay 0 during reset and for exactly 16 cycles after release; the first pll_clk rise occurs at cycle 16+2 after release.
- Framing with defaults: count events until DONE -> 256 pll_clk rising edges and 8 loadEnable pulses, each 2 cycles wide. Each pulse starts 2 cycles after the 32nd falling edge of its word. Consecutive words are separated by a 4-cycle gap.
- Data content: capture writeData on pll_clk rising edges -> words 0x00000007, 0x00000006, ..., 0x00000000 in that order.
- Control-bit override: set R3_VAL=32'hFFFF_FFF8 and R0_VAL=32'hFFFF_FFFF -> captured words are 0xFFFF_FFFB and 0xFFFF_FFF8.
- Timing with HALF_PERIOD=3: each bit spans 6 cycles with pll_clk at 50% duty. writeData never changes while pll_clk=1 or on the cycle pll_clk rises.
- Mid-word reset: pull reset_n low during bit 10 of R5 -> outputs clear asynchronously, before the next clk edge. After release the sequence restarts at R7 and ends with the full 8 words.
